dma_word_fifo: RTL and testbench

Word-wide buffer between the fetch and deposit sides of the DMA datapath. It is the responder to the DMA controller's `fifo_wr_en` and `fifo_rd_en` strobes. A fetch strobe pushes one word from the source bus, and a deposit strobe pops one word toward the destination bus. The block reports occupancy, flags protocol violations with sticky error bits, and counts the bytes delivered so the controller's byte `size` accounting can be cross-checked.

---
 rtl/dma_word_fifo.sv | 67 ++++++
 tb/tb_dma_word_fifo.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/dma_word_fifo.sv
// dma_word_fifo: word FIFO between DMA fetch and deposit sides with occupancy, sticky errors and byte count
module dma_word_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       fifo_wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       fifo_rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     level,
  output logic [31:0]                bytes_out,
  output logic                       ovf,
  output logic                       udf
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic pop_ok, push_ok;
  assign full        = level == LW'(DEPTH);
  assign empty       = level == '0;
  assign almost_full = level >= LW'(AF_THRESH);
  assign pop_ok      = fifo_rd_en && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO can still take a push
  assign push_ok     = fifo_wr_en && (!full || pop_ok);
  always_ff @(posedge clk)
    if (push_ok && !clr && !rst) mem[wp] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      level     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      bytes_out <= '0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
    end else if (clr) begin
      wp        <= '0;
      rp        <= '0;
      level     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      bytes_out <= '0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok) begin
        rp        <= rp + 1'b1;
        rd_data   <= mem[rp];
        bytes_out <= bytes_out + 32'(DATA_W/8);
      end
      rd_valid <= pop_ok;
      level    <= (push_ok && !pop_ok) ? level + 1'b1 : (pop_ok && !push_ok) ? level - 1'b1 : level;
      ovf      <= ovf | (fifo_wr_en && !push_ok);
      udf      <= udf | (fifo_rd_en && !pop_ok);
    end
endmodule

// File: tb/tb_dma_word_fifo.sv
// tb_dma_word_fifo: directed self-checking bench for dma_word_fifo (DATA_W=32, DEPTH=16, AF_THRESH=12)
module tb_dma_word_fifo;
  logic clk = 0, rst = 1, clr = 0, fifo_wr_en = 0, fifo_rd_en = 0;
  logic [31:0] wr_data = 0, rd_data, bytes_out;
  logic rd_valid, full, empty, almost_full, ovf, udf;
  logic [4:0] level;
  int n_cmp = 0, n_err = 0;

  dma_word_fifo #(.DATA_W(32), .DEPTH(16), .AF_THRESH(12)) dut (
    .clk(clk), .rst(rst), .clr(clr), .fifo_wr_en(fifo_wr_en), .wr_data(wr_data),
    .fifo_rd_en(fifo_rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
    .empty(empty), .almost_full(almost_full), .level(level), .bytes_out(bytes_out),
    .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic w, input logic [31:0] d, input logic r, input logic c = 1'b0);
    fifo_wr_en = w; wr_data = d; fifo_rd_en = r; clr = c;
    @(posedge clk); #1;
    fifo_wr_en = 0; fifo_rd_en = 0; clr = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({rd_valid, full, empty, almost_full, ovf, udf} !== 6'b001000) begin n_err++; $display("FAIL reset_flags: got %b want 001000", {rd_valid, full, empty, almost_full, ovf, udf}); end
    n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (rd_data !== 32'd0 || bytes_out !== 32'd0) begin n_err++; $display("FAIL reset_data: got rd_data=%h bytes=%0d want 0/0", rd_data, bytes_out); end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [31:0] w [4];
    w = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    for (int i = 0; i < 4; i++) begin
      cyc(1, w[i], 0);
      n_cmp++; if (level !== 5'(i + 1)) begin n_err++; $display("FAIL basic_push_level: got %0d want %0d", level, i + 1); end
    end
    n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL basic_not_empty: got %b want 0", empty); end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1);
      n_cmp++; if (rd_valid !== 1'b1 || rd_data !== w[i]) begin n_err++; $display("FAIL basic_pop: got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, w[i]); end
    end
    cyc(0, 0, 0);
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_pulse: got %b want 0", rd_valid); end
    n_cmp++; if (level !== 5'd0 || empty !== 1'b1) begin n_err++; $display("FAIL basic_final: got level=%0d empty=%b want 0/1", level, empty); end
    n_cmp++; if (bytes_out !== 32'd16) begin n_err++; $display("FAIL basic_bytes: got %0d want 16", bytes_out); end
  endtask

  task automatic test_overflow;
    cyc(0, 0, 0, 1);
    for (int i = 1; i <= 17; i++) begin
      cyc(1, 32'hA0000000 + i, 0);
      n_cmp++; if (almost_full !== (i >= 12)) begin n_err++; $display("FAIL ovf_almost_full push %0d: got %b want %b", i, almost_full, i >= 12); end
      n_cmp++; if (full !== (i >= 16)) begin n_err++; $display("FAIL ovf_full push %0d: got %b want %b", i, full, i >= 16); end
      n_cmp++; if (ovf !== (i == 17)) begin n_err++; $display("FAIL ovf_flag push %0d: got %b want %b", i, ovf, i == 17); end
    end
    n_cmp++; if (level !== 5'd16) begin n_err++; $display("FAIL ovf_level: got %0d want 16", level); end
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 0, 1);
      n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 32'hA0000000 + i) begin n_err++; $display("FAIL ovf_pop %0d: got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, 32'hA0000000 + i); end
    end
    n_cmp++; if (empty !== 1'b1 || udf !== 1'b0 || ovf !== 1'b1) begin n_err++; $display("FAIL ovf_end: got empty=%b udf=%b ovf=%b want 1/0/1", empty, udf, ovf); end
    n_cmp++; if (bytes_out !== 32'd64) begin n_err++; $display("FAIL ovf_bytes: got %0d want 64", bytes_out); end
  endtask

  task automatic test_underflow;
    cyc(0, 0, 0, 1);
    cyc(1, 32'hCAFE0001, 0);
    cyc(0, 0, 1);
    n_cmp++; if (rd_data !== 32'hCAFE0001) begin n_err++; $display("FAIL udf_first_pop: got %h want cafe0001", rd_data); end
    cyc(0, 0, 1);
    n_cmp++; if (udf !== 1'b1 || rd_valid !== 1'b0) begin n_err++; $display("FAIL udf_refused: got udf=%b v=%b want 1/0", udf, rd_valid); end
    n_cmp++; if (rd_data !== 32'hCAFE0001) begin n_err++; $display("FAIL udf_hold: got %h want cafe0001", rd_data); end
    cyc(1, 32'hCAFE0002, 1);
    n_cmp++; if (level !== 5'd1 || empty !== 1'b0) begin n_err++; $display("FAIL udf_both_level: got level=%0d empty=%b want 1/0", level, empty); end
    n_cmp++; if (udf !== 1'b1 || rd_valid !== 1'b0) begin n_err++; $display("FAIL udf_both_flags: got udf=%b v=%b want 1/0", udf, rd_valid); end
    cyc(0, 0, 1);
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 32'hCAFE0002 || level !== 5'd0) begin n_err++; $display("FAIL udf_after: got v=%b d=%h level=%0d want 1/cafe0002/0", rd_valid, rd_data, level); end
  endtask

  task automatic test_full_stream;
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) cyc(1, 32'hB0000000 + i, 0);
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL stream_full: got %b want 1", full); end
    for (int k = 0; k < 20; k++) begin
      cyc(1, 32'hB0000000 + 16 + k, 1);
      n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 32'hB0000000 + k) begin n_err++; $display("FAIL stream_data %0d: got v=%b d=%h want v=1 d=%h", k, rd_valid, rd_data, 32'hB0000000 + k); end
      n_cmp++; if (level !== 5'd16 || ovf !== 1'b0) begin n_err++; $display("FAIL stream_level %0d: got level=%0d ovf=%b want 16/0", k, level, ovf); end
    end
    n_cmp++; if (bytes_out !== 32'd80) begin n_err++; $display("FAIL stream_bytes: got %0d want 80", bytes_out); end
  endtask

  task automatic test_alternate;
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 64; i++) begin
      cyc(1, {16'hD00D, 16'(i)}, 0);
      n_cmp++; if (level !== 5'd1) begin n_err++; $display("FAIL alt_push %0d: got level=%0d want 1", i, level); end
      cyc(0, 0, 1);
      n_cmp++; if (level !== 5'd0 || rd_valid !== 1'b1 || rd_data !== {16'hD00D, 16'(i)}) begin n_err++; $display("FAIL alt_pop %0d: got level=%0d v=%b d=%h want 0/1/%h", i, level, rd_valid, rd_data, {16'hD00D, 16'(i)}); end
    end
    n_cmp++; if (bytes_out !== 32'd256 || ovf !== 1'b0 || udf !== 1'b0) begin n_err++; $display("FAIL alt_end: got bytes=%0d ovf=%b udf=%b want 256/0/0", bytes_out, ovf, udf); end
  endtask

  task automatic test_clr_rst;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 32'hE0000000 + i, 0);
    cyc(0, 0, 1);
    n_cmp++; if (udf !== 1'b1 || bytes_out !== 32'd4 || rd_data !== 32'hE0000000) begin n_err++; $display("FAIL clr_setup: got udf=%b bytes=%0d d=%h want 1/4/e0000000", udf, bytes_out, rd_data); end
    cyc(1, 32'hEEEEEEEE, 1, 1);
    n_cmp++; if (level !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin n_err++; $display("FAIL clr_level: got level=%0d empty=%b v=%b want 0/1/0", level, empty, rd_valid); end
    n_cmp++; if (rd_data !== 32'd0 || bytes_out !== 32'd0 || udf !== 1'b0 || ovf !== 1'b0) begin n_err++; $display("FAIL clr_state: got d=%h bytes=%0d udf=%b ovf=%b want 0/0/0/0", rd_data, bytes_out, udf, ovf); end
    cyc(1, 32'hF1F1F1F1, 0);
    cyc(0, 0, 1);
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 32'hF1F1F1F1 || level !== 5'd0) begin n_err++; $display("FAIL clr_after: got v=%b d=%h level=%0d want 1/f1f1f1f1/0", rd_valid, rd_data, level); end
    cyc(1, 32'hF2F2F2F2, 0);
    cyc(1, 32'hF3F3F3F3, 0);
    cyc(0, 0, 1);
    #2 rst = 1;
    #1;
    n_cmp++; if (level !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_level: got level=%0d empty=%b v=%b want 0/1/0", level, empty, rd_valid); end
    n_cmp++; if (rd_data !== 32'd0 || bytes_out !== 32'd0) begin n_err++; $display("FAIL rst_async_data: got d=%h bytes=%0d want 0/0", rd_data, bytes_out); end
    @(posedge clk); #1;
    rst = 0;
    cyc(1, 32'hF4F4F4F4, 0);
    cyc(0, 0, 1);
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 32'hF4F4F4F4 || empty !== 1'b1) begin n_err++; $display("FAIL rst_after: got v=%b d=%h empty=%b want 1/f4f4f4f4/1", rd_valid, rd_data, empty); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_underflow();
    test_full_stream();
    test_alternate();
    test_clr_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
